multicycle_ctrl: RTL

- Control FSM for the multicycle RV32I datapath. It is the driving end of the ALU's control/flag interface.
- Sequences fetch, decode, execute, memory and writeback, and generates all datapath enables, the mux selects and the 3-bit ALUControl code.
- Consumes the ALU's Zero and signFlag outputs to resolve branches.
- Supported subset: lw, sw, R-type, I-type ALU, beq, bne, blt, bge, jal.

---
 rtl/riscv_ctrl_pkg.sv | 65 ++++++
 rtl/alu_decoder.sv | 43 ++++
 rtl/multicycle_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_HALT
  } state_t;

  // ALU operation class handed from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Only conditions resolvable from Zero and the raw sign bit are supported
  function automatic logic branch_legal(input logic [2:0] funct3);
    return (funct3 == 3'b000) || (funct3 == 3'b001) ||
           (funct3 == 3'b100) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the ALU operation class and funct fields onto the 3-bit ALUControl code.
// The illegal flag ignores the class and is only meaningful for R/I-type opcodes.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        op5,
  output logic [2:0]  alucontrol,
  output logic        illegal
);

  // slt/sltu have no compare op in the ALU and sra/srai cannot be done by a logical shifter
  always_comb begin
    illegal = 1'b0;
    case (funct3)
      3'b010, 3'b011: illegal = 1'b1;
      3'b101:         illegal = funct7b5;
      default:        illegal = 1'b0;
    endcase
  end

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alucontrol = ALU_SLL;
          3'b100:  alucontrol = ALU_XOR;
          3'b101:  alucontrol = ALU_SRL;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM driving the datapath enables, mux selects and ALUControl.
// Define MULTICYCLE_CTRL_TRAP_EN to halt on illegal instructions instead of treating them as NOPs.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       signFlag,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       IllegalInstr
);

  state_t state;
  aluop_t aluop;
  logic   funct_illegal;
  logic   dec_illegal;
  logic   taken;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (ALUControl),
    .illegal    (funct_illegal)
  );

  always_comb begin
    dec_illegal = 1'b1;
    case (op)
      OP_LW, OP_SW, OP_JAL: dec_illegal = 1'b0;
      OP_RTYPE, OP_ITYPE:   dec_illegal = funct_illegal;
      OP_BRANCH:            dec_illegal = !branch_legal(funct3);
      default:              dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = signFlag;
      3'b101:  taken = !signFlag;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (dec_illegal) begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
            state <= S_HALT;
`else
            state <= S_FETCH;
`endif
          end else begin
            case (op)
              OP_LW, OP_SW: state <= S_MEMADR;
              OP_RTYPE:     state <= S_EXECR;
              OP_ITYPE:     state <= S_EXECI;
              OP_BRANCH:    state <= S_BRANCH;
              OP_JAL:       state <= S_JAL;
              default:      state <= S_FETCH;
            endcase
          end
        end
        S_MEMADR:   state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_HALT:     state <= S_HALT;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Write enables are gated by rst_n so an abandoned instruction never commits
  always_comb begin
    PCWrite      = 1'b0;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    IllegalInstr = 1'b0;
    aluop        = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_IMM;
        IllegalInstr = dec_illegal;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        aluop   = ALUOP_SUB;
        PCWrite = taken;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      S_HALT: IllegalInstr = 1'b1;
      default: ;
    endcase
    if (!rst_n) begin
      PCWrite      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      IllegalInstr = 1'b0;
    end
  end

  always_comb begin
    case (op)
      OP_LW, OP_ITYPE: ImmSrc = IMM_I;
      OP_SW:           ImmSrc = IMM_S;
      OP_BRANCH:       ImmSrc = IMM_B;
      OP_JAL:          ImmSrc = IMM_J;
      default:         ImmSrc = IMM_I;
    endcase
  end

endmodule
